// File: rtl/ip_bus_pkg.sv
// Shared address map defaults, FSM state encoding and slave-select encoding
// for the Z80 bus controller and any other bus master reusing the decoder.
package ip_bus_pkg;

  localparam logic [15:0] DEF_ROM_TOP  = 16'h03FF;
  localparam logic [15:0] DEF_RAM_BASE = 16'hC000;
  localparam logic [7:0]  DEF_IO_LO    = 8'h10;
  localparam logic [7:0]  DEF_IO_HI    = 8'h2F;
  localparam logic [3:0]  DEF_TIMEOUT  = 4'd15;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    STROBE    = 2'd1,
    WAIT_DATA = 2'd2,
    DONE      = 2'd3
  } bus_state_t;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_ROM  = 2'd1,
    SEL_RAM  = 2'd2,
    SEL_IO   = 2'd3
  } slave_sel_t;

  // One-hot bit positions of the decoder's select vector
  localparam int ONEHOT_ROM = 0;
  localparam int ONEHOT_RAM = 1;
  localparam int ONEHOT_IO  = 2;

endpackage

// File: rtl/ip_bus_decode.sv
// Combinational address decoder: maps a memory or I/O cycle to one slave.
// Kept separate so other bus masters can share the same address map.
module ip_bus_decode
  import ip_bus_pkg::*;
#(
  parameter logic [15:0] ROM_TOP  = DEF_ROM_TOP,
  parameter logic [15:0] RAM_BASE = DEF_RAM_BASE,
  parameter logic [7:0]  IO_LO    = DEF_IO_LO,
  parameter logic [7:0]  IO_HI    = DEF_IO_HI
) (
  input  logic        mreq,
  input  logic        iorq,
  input  logic [15:0] address,
  output slave_sel_t  sel,
  output logic [2:0]  sel_onehot,
  output logic        valid
);

  always_comb begin
    sel = SEL_NONE;
    if (mreq && !iorq) begin
      if (address <= ROM_TOP)
        sel = SEL_ROM;
      else if (address >= RAM_BASE)
        sel = SEL_RAM;
    end else if (iorq && !mreq) begin
      if ((address[7:0] >= IO_LO) && (address[7:0] <= IO_HI))
        sel = SEL_IO;
    end
  end

  always_comb begin
    sel_onehot             = 3'b000;
    sel_onehot[ONEHOT_ROM] = (sel == SEL_ROM);
    sel_onehot[ONEHOT_RAM] = (sel == SEL_RAM);
    sel_onehot[ONEHOT_IO]  = (sel == SEL_IO);
    valid                  = (sel != SEL_NONE);
  end

endmodule

// File: rtl/ip_bus_ctrl.sv
// Z80 bus controller: qualifies CPU cycles, strobes the decoded slave for one
// cycle, stalls the CPU until read data returns, and times out silent slaves.
module ip_bus_ctrl
  import ip_bus_pkg::*;
#(
  parameter logic [15:0] ROM_TOP  = DEF_ROM_TOP,
  parameter logic [15:0] RAM_BASE = DEF_RAM_BASE,
  parameter logic [7:0]  IO_LO    = DEF_IO_LO,
  parameter logic [7:0]  IO_HI    = DEF_IO_HI,
  parameter logic [3:0]  TIMEOUT  = DEF_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_n_mreq,
  input  logic        cpu_n_iorq,
  input  logic        cpu_n_rd,
  input  logic        cpu_n_wr,
  input  logic [15:0] cpu_address,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_n_wait,
  output logic        rom_n_cs,
  output logic        ram_n_cs,
  output logic        io_n_cs,
  output logic        bus_n_rd,
  output logic        bus_n_wr,
  output logic [15:0] bus_address,
  output logic [7:0]  bus_wdata,
  input  logic [7:0]  rom_rdata,
  input  logic [7:0]  ram_rdata,
  input  logic [7:0]  io_rdata,
  input  logic        rom_rdata_en,
  input  logic        ram_rdata_en,
  input  logic        io_rdata_en,
  output logic        bus_timeout
);

  logic       mreq, iorq, rd, wr, is_req;
  slave_sel_t dec_sel;
  logic [2:0] dec_onehot;
  logic       dec_valid;

  bus_state_t state;
  slave_sel_t acc_sel;
  logic       acc_read;
  logic [3:0] count;
  logic       slave_en;
  logic [7:0] slave_data;

  // Interrupt acknowledge (mreq+iorq) and rd+wr together are not accesses
  assign mreq   = ~cpu_n_mreq;
  assign iorq   = ~cpu_n_iorq;
  assign rd     = ~cpu_n_rd;
  assign wr     = ~cpu_n_wr;
  assign is_req = (mreq ^ iorq) & (rd ^ wr);

  ip_bus_decode #(
    .ROM_TOP  (ROM_TOP),
    .RAM_BASE (RAM_BASE),
    .IO_LO    (IO_LO),
    .IO_HI    (IO_HI)
  ) u_decode (
    .mreq       (mreq),
    .iorq       (iorq),
    .address    (cpu_address),
    .sel        (dec_sel),
    .sel_onehot (dec_onehot),
    .valid      (dec_valid)
  );

  always_comb begin
    slave_en   = 1'b0;
    slave_data = 8'hFF;
    case (acc_sel)
      SEL_ROM: begin slave_en = rom_rdata_en; slave_data = rom_rdata; end
      SEL_RAM: begin slave_en = ram_rdata_en; slave_data = ram_rdata; end
      SEL_IO:  begin slave_en = io_rdata_en;  slave_data = io_rdata;  end
      default: begin slave_en = 1'b0;         slave_data = 8'hFF;     end
    endcase
  end

  // Wait is forced high during reset so a CPU still holding a read is released
  assign cpu_n_wait = reset |
                      ~(((state == IDLE) && is_req && dec_valid && rd) ||
                        ((state == STROBE) && acc_read) ||
                        (state == WAIT_DATA));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      acc_sel     <= SEL_NONE;
      acc_read    <= 1'b0;
      count       <= 4'd0;
      rom_n_cs    <= 1'b1;
      ram_n_cs    <= 1'b1;
      io_n_cs     <= 1'b1;
      bus_n_rd    <= 1'b1;
      bus_n_wr    <= 1'b1;
      bus_address <= 16'h0000;
      bus_wdata   <= 8'h00;
      cpu_rdata   <= 8'hFF;
      bus_timeout <= 1'b0;
    end else begin
      bus_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (is_req) begin
            if (dec_valid) begin
              bus_address <= cpu_address;
              bus_wdata   <= cpu_wdata;
              acc_read    <= rd;
              acc_sel     <= dec_sel;
              rom_n_cs    <= ~dec_onehot[ONEHOT_ROM];
              ram_n_cs    <= ~dec_onehot[ONEHOT_RAM];
              io_n_cs     <= ~dec_onehot[ONEHOT_IO];
              bus_n_rd    <= ~rd;
              bus_n_wr    <= ~wr;
              state       <= STROBE;
            end else begin
              if (rd)
                cpu_rdata <= 8'hFF;
              state <= DONE;
            end
          end
        end
        STROBE: begin
          rom_n_cs <= 1'b1;
          ram_n_cs <= 1'b1;
          io_n_cs  <= 1'b1;
          bus_n_rd <= 1'b1;
          bus_n_wr <= 1'b1;
          count    <= 4'd0;
          state    <= acc_read ? WAIT_DATA : DONE;
        end
        WAIT_DATA: begin
          if (slave_en) begin
            cpu_rdata <= slave_data;
            state     <= DONE;
          end else if (count == TIMEOUT - 4'd1) begin
            count       <= TIMEOUT;
            cpu_rdata   <= 8'hFF;
            bus_timeout <= 1'b1;
            state       <= DONE;
          end else begin
            count <= count + 4'd1;
          end
        end
        DONE: begin
          // A strobe still held from the finished access must not retrigger
          if (cpu_n_rd && cpu_n_wr)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
